// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// RV64 fetch stage. It holds the program counter and a byte-addressed,
// little-endian instruction memory. It presents one registered 32-bit
// instruction per cycle, with its PC, to decode. A taken branch held in the
// output register redirects the PC to pc_out + (branch_imm << 1).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset (0 = reset)
//   imem_we      in   program-load byte write enable
//   imem_waddr   in   [63:0] program-load byte address (ignored when out of range)
//   imem_wdata   in   [7:0]  program-load byte data
//   stall        in   decode not ready: hold the output register and PC
//   branch_taken in   the branch in the output register resolved taken
//   branch_imm   in   [63:0] sign-extended halfword offset, unshifted
//   instruction  out  [31:0] fetched instruction (registered)
//   pc_out       out  [63:0] PC of the instruction on the instruction output
//   valid        out  instruction/pc_out hold a live instruction
//   done         out  fetch ran past the end of memory (sticky)
//   fault        out  misaligned redirect target (sticky)
//   fetch_count  out  [31:0] number of instructions issued with valid=1
//   state_dbg    out  [1:0]  current FSM state (0 FETCH, 1 DONE, 2 FAULT)
//
// Handshake: an instruction is transferred to decode on every rising edge
// where valid=1 and stall=0. While stall=1 the output register is held
// unchanged. A redirect (branch_taken=1 with valid=1) takes effect on the
// edge it is seen, even while stalled, and is followed by one bubble cycle.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned IMEM_BYTES = 64,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_imm,
  output logic [31:0] instruction,
  output logic [63:0] pc_out,
  output logic        valid,
  output logic        done,
  output logic        fault,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_dbg
);

  localparam int unsigned AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DONE  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  // --------------------------------------------------------------------------
  // Instruction memory (not reset). Reads are asynchronous from the array, so
  // a write and a read of the same byte on one edge return the old data.
  // --------------------------------------------------------------------------
  logic [7:0] mem_q [IMEM_BYTES];

  logic          waddr_ok;
  logic [AW-1:0] waddr_idx;

  assign waddr_ok  = (imem_waddr < 64'(IMEM_BYTES));
  assign waddr_idx = imem_waddr[AW-1:0];

  always_ff @(posedge clk) begin
    if (imem_we && waddr_ok) begin
      mem_q[waddr_idx] <= imem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch word and range check. The check is written as pc <= SIZE-4 so that
  // a PC near 2^64 cannot wrap around and look in range.
  // --------------------------------------------------------------------------
  logic          fetch_ok;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   fetch_word;

  assign fetch_ok = (64'(IMEM_BYTES) >= 64'd4) &&
                    (pc_q <= (64'(IMEM_BYTES) - 64'd4));
  assign idx0 = pc_q[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

  always_comb begin
    fetch_word = 32'd0;
    if (fetch_ok) begin
      fetch_word = {mem_q[idx3], mem_q[idx2], mem_q[idx1], mem_q[idx0]};
    end
  end

  // --------------------------------------------------------------------------
  // Redirect target: halfword offset, 64-bit wrap.
  // --------------------------------------------------------------------------
  logic        redirect;
  logic [63:0] target;

  assign redirect = branch_taken && valid_q;
  assign target   = pc_out_q + (branch_imm << 1);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Priority is redirect > stall > normal fetch.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          if (target[1]) state_d = ST_FAULT;
        end else if (!stall && !fetch_ok) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    done_d   = done_q;
    fault_d  = fault_q;
    count_d  = count_q;
    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          // One bubble; instruction and pc_out keep the branch for visibility.
          pc_d    = target;
          valid_d = 1'b0;
          if (target[1]) fault_d = 1'b1;
        end else if (stall) begin
          // Hold everything.
        end else if (fetch_ok) begin
          instr_d  = fetch_word;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 64'd4;
          count_d  = count_q + 32'd1;
        end else begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE:  valid_d = 1'b0;
      ST_FAULT: valid_d = 1'b0;
      default:  valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc_out_q <= 64'd0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (all registered values)
  // --------------------------------------------------------------------------
  always_comb begin
    instruction = instr_q;
    pc_out      = pc_out_q;
    valid       = valid_q;
    done        = done_q;
    fault       = fault_q;
    fetch_count = count_q;
    state_dbg   = state_q;
  end

endmodule
